pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and freeze controller for a five-stage in-order core.
// Decodes load/enable and bubble/flush controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers from the current hazard
// inputs, and sequences memory-wait freezes, halt draining and timeouts.
//
// Handshake note: mem_req/mem_ack form a level handshake. The MEM-stage
// access is outstanding while mem_req=1 and mem_ack=0. The cycle in which
// mem_ack=1 is the completing cycle, and the pipeline advances on that edge.
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        mem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_err_q, mem_err_d;

    logic        mem_stall;
    logic        load_use;

    // Unreset control values; reset gating is applied at the ports
    logic        pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic        ifid_flush_c, idex_flush_c, exmem_flush_c, memwb_flush_c;

    // Hazard detection: outstanding memory access and load-use dependency
    always_comb begin
        mem_stall = mem_req & ~mem_ack;
        load_use  = 1'b0;
        if (ex_memread && (ex_rd != 5'd0)) begin
            load_use = (id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd));
        end
    end

    // Next-state and output decode; priority is memory stall > halt > branch > load-use
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        memwb_flush_c = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    // Freeze everything upstream of MEM and feed bubbles into WB
                    pc_en_c       = 1'b0;
                    ifid_en_c     = 1'b0;
                    idex_en_c     = 1'b0;
                    exmem_en_c    = 1'b0;
                    memwb_flush_c = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q == 8'hFF) begin
                        state_d   = HALTED;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // Freeze released (or never present): EX/ID were held, so
                    // any deferred branch or load-use is evaluated right here.
                    state_d = RUN;
                    if (mem_halt) begin
                        pc_en_c       = 1'b0;
                        ifid_flush_c  = 1'b1;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                        state_d       = DRAIN;
                    end else if (ex_br_taken) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (load_use) begin
                        pc_en_c      = 1'b0;
                        ifid_en_c    = 1'b0;
                        idex_flush_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Let the halt instruction retire while younger work is squashed
                pc_en_c       = 1'b0;
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
                state_d       = HALTED;
            end
            HALTED: begin
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = 1'b0;
                memwb_en_c = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stall-cycle counter: counts PC-held cycles outside HALTED, saturating
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != HALTED) && !pc_en_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Port drive: every enable and flush is held low while reset is asserted
    always_comb begin
        pc_en       = pc_en_c       & ~reset;
        ifid_en     = ifid_en_c     & ~reset;
        idex_en     = idex_en_c     & ~reset;
        exmem_en    = exmem_en_c    & ~reset;
        memwb_en    = memwb_en_c    & ~reset;
        ifid_flush  = ifid_flush_c  & ~reset;
        idex_flush  = idex_flush_c  & ~reset;
        exmem_flush = exmem_flush_c & ~reset;
        memwb_flush = memwb_flush_c & ~reset;
        halted      = (state_q == HALTED);
        mem_err     = mem_err_q;
        stall_cnt   = stall_cnt_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change just after the falling
// edge, combinational outputs are sampled 1 ns later, and registered
// outputs are sampled after the following falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_br_taken;
    logic        mem_req, mem_ack, mem_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halted, mem_err;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;

    logic [4:0]  ens;
    logic [3:0]  fls;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;

    // Bit order of the packed views: {pc,ifid,idex,exmem,memwb} and {ifid,idex,exmem,memwb}
    localparam logic [4:0] EN_ALL    = 5'b11111;
    localparam logic [4:0] EN_NONE   = 5'b00000;
    localparam logic [4:0] EN_LU     = 5'b00111;
    localparam logic [4:0] EN_FREEZE = 5'b00001;
    localparam logic [4:0] EN_HALT   = 5'b01111;
    localparam logic [3:0] FL_NONE   = 4'b0000;
    localparam logic [3:0] FL_LU     = 4'b0100;
    localparam logic [3:0] FL_BR     = 4'b1100;
    localparam logic [3:0] FL_FREEZE = 4'b0001;
    localparam logic [3:0] FL_HALT   = 4'b1110;

    assign ens = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fls = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_halt    (mem_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .halted      (halted),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; ex_br_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt);
        ex_memread = 1'b1; ex_rd = rd;
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        mem_req = 1'b1; ex_br_taken = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ens !== EN_NONE || fls !== FL_NONE) begin
            errors++;
            $display("FAIL reset_outputs: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_NONE, FL_NONE);
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd0 || halted !== 1'b0 || mem_err !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: stall_cnt=%0d halted=%b mem_err=%b state=%0d expected 0 0 0 0",
                     stall_cnt, halted, mem_err, state_dbg);
        end
        clear_inputs();
        reset = 1'b0;
        exp_stall = 0;
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE) begin
            errors++;
            $display("FAIL post_reset_default: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_NONE);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        // Hazard through rs
        drive_load(5'd8, 5'd8, 1'b1, 5'd3, 1'b0);
        #1;
        checks++;
        if (ens !== EN_LU || fls !== FL_LU) begin
            errors++;
            $display("FAIL load_use_rs: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_LU, FL_LU);
        end
        @(negedge clk);
        exp_stall++;
        clear_inputs();
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL load_use_release: ens=%b fls=%b stall_cnt=%0d expected ens=%b fls=%b stall_cnt=%0d",
                     ens, fls, stall_cnt, EN_ALL, FL_NONE, exp_stall);
        end
        // Hazard through rt
        drive_load(5'd17, 5'd2, 1'b1, 5'd17, 1'b1);
        #1;
        checks++;
        if (ens !== EN_LU || fls !== FL_LU) begin
            errors++;
            $display("FAIL load_use_rt: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_LU, FL_LU);
        end
        @(negedge clk);
        exp_stall++;
        // Register 0 never creates a dependency
        drive_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE) begin
            errors++;
            $display("FAIL load_use_r0: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_NONE);
        end
        @(negedge clk);
        // Matching register that the ID instruction does not read
        drive_load(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE) begin
            errors++;
            $display("FAIL load_use_unused: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_NONE);
        end
        @(negedge clk);
        // Not a load
        drive_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        ex_memread = 1'b0;
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE) begin
            errors++;
            $display("FAIL load_use_noload: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_NONE);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL load_use_count: stall_cnt=%0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_branch_load_use();
        drive_load(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_BR) begin
            errors++;
            $display("FAIL branch_load_use: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_BR);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL branch_count: stall_cnt=%0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ens !== EN_FREEZE || fls !== FL_FREEZE) begin
                errors++;
                $display("FAIL mem_wait_freeze%0d: ens=%b fls=%b expected ens=%b fls=%b",
                         i, ens, fls, EN_FREEZE, FL_FREEZE);
            end
            @(negedge clk);
            exp_stall++;
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_NONE || state_dbg !== 2'd1) begin
            errors++;
            $display("FAIL mem_wait_release: ens=%b fls=%b state=%0d expected ens=%b fls=%b state=1",
                     ens, fls, state_dbg, EN_ALL, FL_NONE);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_stall) || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL mem_wait_count: stall_cnt=%0d state=%0d expected %0d state=0",
                     stall_cnt, state_dbg, exp_stall);
        end
    endtask

    task automatic test_deferred_branch();
        mem_req = 1'b1; mem_ack = 1'b0; ex_br_taken = 1'b1;
        drive_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ens !== EN_FREEZE || fls !== FL_FREEZE) begin
                errors++;
                $display("FAIL defer_freeze%0d: ens=%b fls=%b expected ens=%b fls=%b",
                         i, ens, fls, EN_FREEZE, FL_FREEZE);
            end
            @(negedge clk);
            exp_stall++;
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (ens !== EN_ALL || fls !== FL_BR) begin
            errors++;
            $display("FAIL defer_branch_release: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_ALL, FL_BR);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL defer_count: stall_cnt=%0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_reset_in_wait();
        mem_req = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        clear_inputs();
        checks++;
        if (state_dbg !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_from_wait: state=%0d stall_cnt=%0d expected state=0 stall_cnt=0",
                     state_dbg, stall_cnt);
        end
    endtask

    task automatic test_halt();
        mem_halt = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if (ens !== EN_HALT || fls !== FL_HALT) begin
            errors++;
            $display("FAIL halt_first: ens=%b fls=%b expected ens=%b fls=%b", ens, fls, EN_HALT, FL_HALT);
        end
        @(negedge clk);
        exp_stall++;
        clear_inputs();
        #1;
        checks++;
        if (ens !== EN_HALT || fls !== FL_HALT || state_dbg !== 2'd2 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: ens=%b fls=%b state=%0d halted=%b expected ens=%b fls=%b state=2 halted=0",
                     ens, fls, state_dbg, halted, EN_HALT, FL_HALT);
        end
        @(negedge clk);
        exp_stall++;
        ex_br_taken = 1'b1;
        drive_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (halted !== 1'b1 || mem_err !== 1'b0 || ens !== EN_NONE || fls !== FL_NONE ||
            stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL halt_held: halted=%b mem_err=%b ens=%b fls=%b stall_cnt=%0d expected 1 0 %b %b %0d",
                     halted, mem_err, ens, fls, stall_cnt, EN_NONE, FL_NONE, exp_stall);
        end
        clear_inputs();
        do_reset();
        #1;
        checks++;
        if (halted !== 1'b0 || ens !== EN_ALL || fls !== FL_NONE || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b ens=%b fls=%b stall_cnt=%0d expected 0 %b %b 0",
                     halted, ens, fls, stall_cnt, EN_ALL, FL_NONE);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        mem_req = 1'b1; mem_ack = 1'b0;
        // First stalled cycle in RUN, then 255 MEM_WAIT cycles still below the limit
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            exp_stall++;
        end
        #1;
        checks++;
        if (halted !== 1'b0 || state_dbg !== 2'd1 || ens !== EN_FREEZE || fls !== FL_FREEZE) begin
            errors++;
            $display("FAIL timeout_last_wait: halted=%b state=%0d ens=%b fls=%b expected 0 1 %b %b",
                     halted, state_dbg, ens, fls, EN_FREEZE, FL_FREEZE);
        end
        @(negedge clk);
        exp_stall++;
        checks++;
        if (halted !== 1'b1 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_halt: halted=%b mem_err=%b expected 1 1", halted, mem_err);
        end
        cyc = 257;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        checks++;
        if (ens !== EN_NONE || fls !== FL_NONE || halted !== 1'b1 || mem_err !== 1'b1 ||
            stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL timeout_held: ens=%b fls=%b halted=%b mem_err=%b stall_cnt=%0d expected %b %b 1 1 %0d",
                     ens, fls, halted, mem_err, stall_cnt, EN_NONE, FL_NONE, exp_stall);
        end
        clear_inputs();
        do_reset();
        checks++;
        if (mem_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset: mem_err=%b halted=%b expected 0 0", mem_err, halted);
        end
    endtask

    task automatic test_saturation();
        drive_load(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
        end
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_saturate: stall_cnt=%h expected ffff", stall_cnt);
        end
        clear_inputs();
        do_reset();
    endtask

    // Test sequence and final report
    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_deferred_branch();
        test_reset_in_wait();
        test_halt();
        test_timeout();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
